// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the pwm_timer register slave and its configuration masters.
// Register map, FSM encoding, control-register bit positions and the write payload.
package pwm_timer_pkg;

   localparam int unsigned WB_AW = 16;
   localparam int unsigned WB_DW = 16;

   localparam logic [WB_AW-1:0] REG_CTRL = 16'h0000;
   localparam logic [WB_AW-1:0] REG_DIV  = 16'h0002;
   localparam logic [WB_AW-1:0] REG_PER  = 16'h0004;
   localparam logic [WB_AW-1:0] REG_DC   = 16'h0006;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_POL_BIT = 1;
   localparam int unsigned CTRL_IRQ_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] data;
   } wb_wr_t;

   // True when adr hits one of the four timer registers relative to base.
   function automatic logic adr_valid(input logic [WB_AW-1:0] adr, input logic [WB_AW-1:0] base);
      logic [WB_AW-1:0] off;
      off = adr - base;
      return (off == REG_CTRL) || (off == REG_DIV) || (off == REG_PER) || (off == REG_DC);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after start, wrapping.
// Returns a one-hot grant, all zero when nobody requests.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] start,
   output logic [N-1:0]     gnt_c
);

   logic found;

   always_comb begin
      gnt_c = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && req[k] && (k >= 32'(start))) begin
            gnt_c[k] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && req[k] && (k < 32'(start))) begin
            gnt_c[k] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Wishbone-classic write master sharing the pwm_timer registers between N_REQ requesters.
// Round-robin grant, address check, one write per grant, ack timeout reported as error.
module pwm_cfg_arbiter
   import pwm_timer_pkg::*;
#(
   parameter int unsigned      N_REQ    = 2,
   parameter logic [15:0]      BASE_ADR = 16'h0000,
   parameter int unsigned      TIMEOUT  = 16,
   parameter int unsigned      TO_W     = 5
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [WB_AW*N_REQ-1:0]   i_adr,
   input  logic [WB_DW*N_REQ-1:0]   i_data,
   output logic [N_REQ-1:0]         o_gnt,
   output logic [N_REQ-1:0]         o_done,
   output logic [N_REQ-1:0]         o_err,
   output logic                     o_busy,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_we,
   output logic [WB_AW-1:0]         o_wb_adr,
   output logic [WB_DW-1:0]         o_wb_data,
   input  logic                     i_wb_ack
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t           state, state_d;
   logic [PTR_W-1:0] ptr, ptr_d, idx, idx_d, start_c, win_idx_c;
   logic             fresh, fresh_d;
   logic [TO_W-1:0]  timer, timer_d;
   logic [N_REQ-1:0] win_c, gnt_d, done_d, err_d;
   logic             cyc, cyc_d, busy_d;
   wb_wr_t           wr, wr_d, sel_c;

   // Search starts just past the last winner, or at requester 0 straight after reset.
   always_comb begin
      if (fresh || (ptr == PTR_W'(N_REQ - 1))) start_c = '0;
      else                                      start_c = ptr + PTR_W'(1);
   end

   rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
      .req   (i_req),
      .start (start_c),
      .gnt_c (win_c)
   );

   always_comb begin
      sel_c     = '0;
      win_idx_c = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (win_c[k]) begin
            sel_c.adr  = i_adr[WB_AW*k +: WB_AW];
            sel_c.data = i_data[WB_DW*k +: WB_DW];
            win_idx_c  = PTR_W'(k);
         end
      end
   end

   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      idx_d   = idx;
      fresh_d = fresh;
      timer_d = timer;
      gnt_d   = o_gnt;
      done_d  = '0;
      err_d   = '0;
      cyc_d   = cyc;
      wr_d    = wr;
      case (state)
         ST_IDLE: begin
            if (|i_req) begin
               gnt_d   = win_c;
               idx_d   = win_idx_c;
               timer_d = '0;
               if (adr_valid(sel_c.adr, BASE_ADR)) begin
                  state_d = ST_BUS;
                  cyc_d   = 1'b1;
                  wr_d    = sel_c;
               end else begin
                  state_d = ST_RESP;
                  err_d   = win_c;
               end
            end
         end
         ST_BUS: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (i_wb_ack) begin
               state_d = ST_RESP;
               cyc_d   = 1'b0;
               wr_d    = '0;
               done_d  = o_gnt;
            end else if (timer == TO_LAST) begin
               state_d = ST_RESP;
               cyc_d   = 1'b0;
               wr_d    = '0;
               err_d   = o_gnt;
            end else begin
               timer_d = timer + TO_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            ptr_d   = idx;
            fresh_d = 1'b0;
            gnt_d   = '0;
            timer_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         idx    <= '0;
         fresh  <= 1'b1;
         timer  <= '0;
         o_gnt  <= '0;
         o_done <= '0;
         o_err  <= '0;
         o_busy <= 1'b0;
         cyc    <= 1'b0;
         wr     <= '0;
      end else begin
         state  <= state_d;
         ptr    <= ptr_d;
         idx    <= idx_d;
         fresh  <= fresh_d;
         timer  <= timer_d;
         o_gnt  <= gnt_d;
         o_done <= done_d;
         o_err  <= err_d;
         o_busy <= busy_d;
         cyc    <= cyc_d;
         wr     <= wr_d;
      end
   end

   assign o_wb_cyc  = cyc;
   assign o_wb_stb  = cyc;
   assign o_wb_we   = cyc;
   assign o_wb_adr  = wr.adr;
   assign o_wb_data = wr.data;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed bench for pwm_cfg_arbiter with a registered-ack slave model and a
// scoreboard of expected bus writes and done/err pulses.
module tb_pwm_cfg_arbiter;

   typedef struct packed {
      logic [15:0] adr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic        err;
      logic [31:0] idx;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [15:0] radr [2];
   logic [15:0] rdat [2];
   logic [31:0] adr_bus, dat_bus;
   logic [1:0]  gnt, done, err;
   logic        busy, wb_cyc, wb_stb, wb_we, ack;
   logic [15:0] wb_adr, wb_dat;

   int   n_pass  = 0;
   int   n_total = 0;
   int   mode    = 0;
   int   scnt    = 0;
   int   run_len = 0;
   int   last_len = 0;
   bit   ok;
   wr_t  exp_wr [$];
   rsp_t exp_rsp [$];
   wr_t  mon_w;
   rsp_t mon_r;

   assign adr_bus = {radr[1], radr[0]};
   assign dat_bus = {rdat[1], rdat[0]};

   pwm_cfg_arbiter dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (req),
      .i_adr     (adr_bus),
      .i_data    (dat_bus),
      .o_gnt     (gnt),
      .o_done    (done),
      .o_err     (err),
      .o_busy    (busy),
      .o_wb_cyc  (wb_cyc),
      .o_wb_stb  (wb_stb),
      .o_wb_we   (wb_we),
      .o_wb_adr  (wb_adr),
      .o_wb_data (wb_dat),
      .i_wb_ack  (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave: mode 0 acks one cycle after stb, 1 never acks, 2 acks in the 16th bus cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack  <= 1'b0;
         scnt <= 0;
      end else begin
         scnt <= wb_cyc ? scnt + 1 : 0;
         case (mode)
            0:       ack <= wb_cyc && wb_stb && !ack;
            2:       ack <= wb_cyc && wb_stb && (scnt == 14);
            default: ack <= 1'b0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
      wr_t w;
      w.adr  = a;
      w.data = d;
      exp_wr.push_back(w);
   endtask

   task automatic push_rsp(input logic e, input int i);
      rsp_t r;
      r.err = e;
      r.idx = 32'(i);
      exp_rsp.push_back(r);
   endtask

   task automatic wait_pulse(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if ((|done) || (|err)) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Scoreboard side: bus handshakes and response pulses are matched in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_cyc && ack) begin
            check("wr_expected", 32'(exp_wr.size() > 0), 32'(1));
            if (exp_wr.size() > 0) begin
               mon_w = exp_wr.pop_front();
               check("wr_adr", 32'(wb_adr), 32'(mon_w.adr));
               check("wr_data", 32'(wb_dat), 32'(mon_w.data));
               check("wr_we_stb", 32'({wb_we, wb_stb}), 32'(2'b11));
            end
         end
         if ((|done) || (|err)) begin
            check("rsp_expected", 32'(exp_rsp.size() > 0), 32'(1));
            if (exp_rsp.size() > 0) begin
               mon_r = exp_rsp.pop_front();
               check("rsp_done", 32'(done), mon_r.err ? 32'(0) : (32'(1) << mon_r.idx));
               check("rsp_err", 32'(err), mon_r.err ? (32'(1) << mon_r.idx) : 32'(0));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (wb_cyc) begin
         run_len++;
      end else if (run_len != 0) begin
         last_len = run_len;
         run_len  = 0;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      req     = 2'b00;
      radr[0] = '0; radr[1] = '0;
      rdat[0] = '0; rdat[1] = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'(0));
      check("rst_pulses", 32'({done, err}), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_wb_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'(0));
      check("rst_wb_adr", 32'(wb_adr), 32'(0));
      check("rst_wb_data", 32'(wb_dat), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Two requesters held high: grants alternate starting with requester 0.
      radr[0] = 16'h0002; rdat[0] = 16'h1000;
      radr[1] = 16'h0006; rdat[1] = 16'h1001;
      for (int i = 0; i < 8; i++) begin
         push_wr((i % 2 == 1) ? 16'h0006 : 16'h0002, 16'(16'h1000 + i));
         push_rsp(1'b0, i % 2);
      end
      req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         wait_pulse(20, ok);
         check("t2_pulse_seen", 32'(ok), 32'(1));
         check("t2_order_done", 32'(done), 32'(1) << (i % 2));
         check("t2_order_gnt", 32'(gnt), 32'(1) << (i % 2));
         rdat[i % 2] = 16'(16'h1000 + i + 2);
         if (i >= 6) req[i % 2] = 1'b0;
      end
      @(negedge clk);

      // Single write with exact latency.
      radr[0] = 16'h0004; rdat[0] = 16'h0064; req = 2'b01;
      push_wr(16'h0004, 16'h0064);
      push_rsp(1'b0, 0);
      check("t1_idle", 32'(busy), 32'(0));
      @(negedge clk);
      check("t1_wb_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'(3'b111));
      check("t1_adr", 32'(wb_adr), 32'(16'h0004));
      check("t1_data", 32'(wb_dat), 32'(16'h0064));
      check("t1_gnt", 32'(gnt), 32'(2'b01));
      check("t1_busy", 32'(busy), 32'(1));
      @(negedge clk);
      check("t1_hold_cyc", 32'(wb_cyc), 32'(1));
      check("t1_no_early_done", 32'(done), 32'(0));
      @(negedge clk);
      check("t1_done", 32'(done), 32'(2'b01));
      check("t1_cyc_drop", 32'(wb_cyc), 32'(0));
      check("t1_adr_zero", 32'(wb_adr), 32'(0));
      check("t1_gnt_resp", 32'(gnt), 32'(2'b01));
      req = 2'b00;
      @(negedge clk);
      check("t1_done_1cyc", 32'(done), 32'(0));
      check("t1_busy_clr", 32'(busy), 32'(0));
      check("t1_gnt_clr", 32'(gnt), 32'(0));

      // Bad address: error without any bus cycle.
      radr[1] = 16'h0003; rdat[1] = 16'h5555; req = 2'b10;
      push_rsp(1'b1, 1);
      @(negedge clk);
      check("t3_err", 32'(err), 32'(2'b10));
      check("t3_gnt", 32'(gnt), 32'(2'b10));
      check("t3_no_cyc", 32'(wb_cyc), 32'(0));
      req = 2'b00;
      @(negedge clk);
      check("t3_err_1cyc", 32'(err), 32'(0));
      check("t3_no_cyc2", 32'(wb_cyc), 32'(0));
      check("t3_busy_clr", 32'(busy), 32'(0));

      // Slave never acks: timeout after exactly 16 bus cycles.
      mode = 1;
      radr[0] = 16'h0000; rdat[0] = 16'h00AA; req = 2'b01;
      push_rsp(1'b1, 0);
      repeat (16) @(negedge clk);
      check("t4_cyc_last", 32'(wb_cyc), 32'(1));
      check("t4_no_early_err", 32'(err), 32'(0));
      @(negedge clk);
      check("t4_err", 32'(err), 32'(2'b01));
      check("t4_cyc_drop", 32'(wb_cyc), 32'(0));
      req = 2'b00;
      @(negedge clk);
      check("t4_cyc_len", 32'(last_len), 32'(16));
      check("t4_busy_clr", 32'(busy), 32'(0));
      mode = 0;
      radr[0] = 16'h0006; rdat[0] = 16'h0055; req = 2'b01;
      push_wr(16'h0006, 16'h0055);
      push_rsp(1'b0, 0);
      wait_pulse(10, ok);
      check("t4_next_seen", 32'(ok), 32'(1));
      check("t4_next_done", 32'(done), 32'(2'b01));
      req = 2'b00;
      @(negedge clk);

      // Ack lands on the last timer cycle: done wins.
      mode = 2;
      radr[1] = 16'h0002; rdat[1] = 16'h0BEE; req = 2'b10;
      push_wr(16'h0002, 16'h0BEE);
      push_rsp(1'b0, 1);
      repeat (17) @(negedge clk);
      check("t5_done", 32'(done), 32'(2'b10));
      check("t5_no_err", 32'(err), 32'(0));
      req = 2'b00;
      @(negedge clk);
      check("t5_cyc_len", 32'(last_len), 32'(16));
      mode = 0;

      // Reset in the middle of a bus cycle.
      mode = 1;
      radr[0] = 16'h0004; rdat[0] = 16'h1234; req = 2'b01;
      repeat (2) @(negedge clk);
      check("t6_in_bus", 32'(wb_cyc), 32'(1));
      rst_n = 1'b0;
      req   = 2'b00;
      #1;
      check("t6_async_ctl", 32'({wb_cyc, wb_stb}), 32'(0));
      check("t6_async_gnt", 32'(gnt), 32'(0));
      check("t6_async_busy", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mode  = 0;
      @(negedge clk);
      radr[1] = 16'h0002; rdat[1] = 16'h4321; req = 2'b10;
      push_wr(16'h0002, 16'h4321);
      push_rsp(1'b0, 1);
      @(negedge clk);
      check("t6_gnt_req1", 32'(gnt), 32'(2'b10));
      check("t6_adr", 32'(wb_adr), 32'(16'h0002));
      wait_pulse(10, ok);
      check("t6_seen", 32'(ok), 32'(1));
      check("t6_done", 32'(done), 32'(2'b10));
      req = 2'b00;
      repeat (2) @(negedge clk);

      check("sb_wr_drained", 32'(exp_wr.size()), 32'(0));
      check("sb_rsp_drained", 32'(exp_rsp.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
